// File: rtl/spm_sched_pkg.sv
// Shared definitions for the survivor-path memory scheduler.
//
// Contents:
//   NBANK      number of survivor banks (write + traceback + decode)
//   TB_BANKS   banks walked during traceback before the decode bank
//   TB_READS   reads per traceback sequence (5 banks x 32 words)
//   FILL_MAX   completed windows needed before a traceback can start
//   bank_idx_t bank index type, values 0..NBANK-1
//   tb_state_t traceback sequencer state
//   bank_inc / bank_dec  bank index step with wrap modulo NBANK
package spm_sched_pkg;

    localparam int NBANK    = 6;
    localparam int TB_BANKS = 4;
    localparam int TB_READS = 160;
    localparam int FILL_MAX = TB_BANKS + 1;

    typedef logic [2:0] bank_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } tb_state_t;

    function automatic bank_idx_t bank_inc(input bank_idx_t b);
        return (b == bank_idx_t'(NBANK - 1)) ? bank_idx_t'(0) : b + 3'd1;
    endfunction

    function automatic bank_idx_t bank_dec(input bank_idx_t b);
        return (b == bank_idx_t'(0)) ? bank_idx_t'(NBANK - 1) : b - 3'd1;
    endfunction

endpackage

// File: rtl/spm_bank_rdmux.sv
// Read-return path of the survivor-path memory scheduler.
//
// The banks answer one cycle after the read strobe, so the bank index and the
// valid flag of the issued read are registered here once more and then used to
// pick the returning word out of the six bank outputs.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rd_en_in              a read strobe is on the bank ports this cycle
//   bank_in               bank index of that read
//   rdata0_in..rdata5_in  synchronous-read data from banks 0..5
//   valid_out             rdata_out carries a returned read word
//   rdata_out             selected bank word, zero when no read returns
module spm_bank_rdmux
    import spm_sched_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_en_in,
    input  logic [2:0]       bank_in,
    input  logic [WIDTH-1:0] rdata0_in,
    input  logic [WIDTH-1:0] rdata1_in,
    input  logic [WIDTH-1:0] rdata2_in,
    input  logic [WIDTH-1:0] rdata3_in,
    input  logic [WIDTH-1:0] rdata4_in,
    input  logic [WIDTH-1:0] rdata5_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] rdata_out
);

    bank_idx_t        sel_q;
    logic             vld_q;
    logic [WIDTH-1:0] mux;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q <= '0;
            vld_q <= 1'b0;
        end else begin
            sel_q <= bank_in;
            vld_q <= rd_en_in;
        end
    end

    // NOTE: the default at the top of the block keeps every path assigned, so
    // no latch is inferred for bank indices outside 0..5.
    always_comb begin
        mux = '0;
        case (sel_q)
            3'd0:    mux = rdata0_in;
            3'd1:    mux = rdata1_in;
            3'd2:    mux = rdata2_in;
            3'd3:    mux = rdata3_in;
            3'd4:    mux = rdata4_in;
            3'd5:    mux = rdata5_in;
            default: mux = '0;
        endcase
    end

    // Bank outputs are undefined when no read was strobed; keep the returned
    // word at zero outside valid cycles.
    assign valid_out = vld_q;
    assign rdata_out = vld_q ? mux : '0;

endmodule

// File: rtl/spm_bank_scheduler.sv
// Survivor-path memory scheduler for the Viterbi decoder.
//
// Six 32-word survivor banks rotate roles every 32 trellis steps: one write
// bank, four traceback banks and one decode bank. Survivor words are written
// to the write bank in ascending address order; traceback reads walk the
// completed banks in descending trellis order (newest bank first, address 31
// down to 0), ending with the decode bank. The write bank is always the bank
// after the newest completed one, so it is never part of the read set and
// writes and reads can share a cycle.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   sym_valid_in, wdata_in  one survivor word per trellis step
//   tb_rd_req_in            traceback read request, at most one per cycle
//   rdata0_in..rdata5_in    synchronous-read data from banks 0..5
//   addr0_out..addr5_out    per-bank address (registered)
//   cs_out, we_out          per-bank chip select / write strobe (registered)
//   wdata_out               write data shared by all banks (registered)
//   rdata_out, rd_valid_out read word returned two cycles after its request
//   rd_decode_out           returned word comes from the decode bank
//   tb_start_out            pulse: new traceback window ready
//   tb_busy_out             traceback sequence in progress
//   tb_done_out             pulse with the last word of a sequence
//   overrun_out             sticky: window boundary reached while busy
//   wbank_out               current write bank index
//   ovr_cnt_out             saturating overrun event count, present only
//                           when SPM_SCHED_OVR_CNT_EN is defined
module spm_bank_scheduler
    import spm_sched_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sym_valid_in,
    input  logic [WIDTH-1:0] wdata_in,
    input  logic             tb_rd_req_in,
    input  logic [WIDTH-1:0] rdata0_in,
    input  logic [WIDTH-1:0] rdata1_in,
    input  logic [WIDTH-1:0] rdata2_in,
    input  logic [WIDTH-1:0] rdata3_in,
    input  logic [WIDTH-1:0] rdata4_in,
    input  logic [WIDTH-1:0] rdata5_in,
    output logic [AW-1:0]    addr0_out,
    output logic [AW-1:0]    addr1_out,
    output logic [AW-1:0]    addr2_out,
    output logic [AW-1:0]    addr3_out,
    output logic [AW-1:0]    addr4_out,
    output logic [AW-1:0]    addr5_out,
    output logic [5:0]       cs_out,
    output logic [5:0]       we_out,
    output logic [WIDTH-1:0] wdata_out,
    output logic [WIDTH-1:0] rdata_out,
    output logic             rd_valid_out,
    output logic             rd_decode_out,
    output logic             tb_start_out,
    output logic             tb_busy_out,
    output logic             tb_done_out,
    output logic             overrun_out,
    output logic [2:0]       wbank_out
`ifdef SPM_SCHED_OVR_CNT_EN
    ,
    output logic [7:0]       ovr_cnt_out
`endif
);

    // ---------------------------------------------------------------- state
    bank_idx_t        wbank_q;
    logic [AW-1:0]    wptr_q;
    logic [2:0]       fill_q;
    bank_idx_t        rd_bank_q;
    logic [AW-1:0]    rd_addr_q;
    logic [7:0]       rd_cnt_q;
    tb_state_t        state_q, state_d;

    // Bank port registers
    logic [NBANK-1:0] cs_q, we_q, cs_d, we_d;
    logic [AW-1:0]    addr_q [NBANK];
    logic [AW-1:0]    addr_d [NBANK];
    logic [WIDTH-1:0] wdata_q;

    // Read pipeline: stage 1 travels with the bank strobe, stage 2 with data
    logic             rd_s1_q, dec_s1_q, last_s1_q;
    bank_idx_t        bank_s1_q;
    logic             rd_decode_q, tb_done_q, tb_start_q, overrun_q;

    // -------------------------------------------------------- event decode
    logic busy, boundary, start, ovr_evt, rd_fire, rd_last, rd_dec;

    assign busy     = (state_q == ST_BUSY);
    assign boundary = sym_valid_in && (wptr_q == '1);
    // Fill reaches (or already sits at) FILL_MAX on this boundary.
    assign start    = boundary && (fill_q >= 3'(FILL_MAX - 1));
    assign ovr_evt  = boundary && busy;
    // A request in a boundary cycle is dropped: the sequence restarts there.
    assign rd_fire  = tb_rd_req_in && busy && !boundary;
    assign rd_last  = (rd_cnt_q == 8'(TB_READS - 1));
    assign rd_dec   = (rd_cnt_q >= 8'(TB_BANKS << AW));

    // ---------------------------------------------------- sequencer FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_BUSY;
            ST_BUSY: begin
                if (start)                   state_d = ST_BUSY;
                else if (rd_fire && rd_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------- write and read pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbank_q   <= '0;
            wptr_q    <= '0;
            fill_q    <= '0;
            rd_bank_q <= '0;
            rd_addr_q <= '0;
            rd_cnt_q  <= '0;
        end else begin
            if (sym_valid_in) begin
                wptr_q <= wptr_q + AW'(1);
                if (boundary) begin
                    wbank_q <= bank_inc(wbank_q);
                    if (fill_q != 3'(FILL_MAX)) fill_q <= fill_q + 3'd1;
                end
            end
            if (start) begin
                // Newest completed bank is the one just closed.
                rd_bank_q <= wbank_q;
                rd_addr_q <= '1;
                rd_cnt_q  <= '0;
            end else if (rd_fire) begin
                rd_addr_q <= rd_addr_q - AW'(1);
                if (rd_addr_q == '0) rd_bank_q <= bank_dec(rd_bank_q);
                rd_cnt_q  <= rd_cnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------ bank port requests
    always_comb begin
        cs_d = '0;
        we_d = '0;
        for (int b = 0; b < NBANK; b++) addr_d[b] = '0;
        if (sym_valid_in) begin
            cs_d[wbank_q]   = 1'b1;
            we_d[wbank_q]   = 1'b1;
            addr_d[wbank_q] = wptr_q;
        end
        if (rd_fire) begin
            cs_d[rd_bank_q]   = 1'b1;
            addr_d[rd_bank_q] = rd_addr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q        <= '0;
            we_q        <= '0;
            wdata_q     <= '0;
            for (int b = 0; b < NBANK; b++) addr_q[b] <= '0;
            rd_s1_q     <= 1'b0;
            dec_s1_q    <= 1'b0;
            last_s1_q   <= 1'b0;
            bank_s1_q   <= '0;
            rd_decode_q <= 1'b0;
            tb_done_q   <= 1'b0;
            tb_start_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cs_q        <= cs_d;
            we_q        <= we_d;
            wdata_q     <= sym_valid_in ? wdata_in : '0;
            for (int b = 0; b < NBANK; b++) addr_q[b] <= addr_d[b];
            rd_s1_q     <= rd_fire;
            dec_s1_q    <= rd_fire && rd_dec;
            last_s1_q   <= rd_fire && rd_last;
            bank_s1_q   <= rd_fire ? rd_bank_q : '0;
            rd_decode_q <= dec_s1_q;
            tb_done_q   <= last_s1_q;
            tb_start_q  <= start;
            if (ovr_evt) overrun_q <= 1'b1;
        end
    end

    // ----------------------------------------------------- read return
    spm_bank_rdmux #(
        .WIDTH (WIDTH)
    ) u_rdmux (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_en_in  (rd_s1_q),
        .bank_in   (bank_s1_q),
        .rdata0_in (rdata0_in),
        .rdata1_in (rdata1_in),
        .rdata2_in (rdata2_in),
        .rdata3_in (rdata3_in),
        .rdata4_in (rdata4_in),
        .rdata5_in (rdata5_in),
        .valid_out (rd_valid_out),
        .rdata_out (rdata_out)
    );

`ifdef SPM_SCHED_OVR_CNT_EN
    logic [7:0] ovr_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          ovr_cnt_q <= '0;
        else if (ovr_evt && ovr_cnt_q != '1)   ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end

    assign ovr_cnt_out = ovr_cnt_q;
`else
    // Without the counter the sticky overrun flag is the only record.
`endif

    // ---------------------------------------------------------- outputs
    assign addr0_out     = addr_q[0];
    assign addr1_out     = addr_q[1];
    assign addr2_out     = addr_q[2];
    assign addr3_out     = addr_q[3];
    assign addr4_out     = addr_q[4];
    assign addr5_out     = addr_q[5];
    assign cs_out        = cs_q;
    assign we_out        = we_q;
    assign wdata_out     = wdata_q;
    assign rd_decode_out = rd_decode_q;
    assign tb_start_out  = tb_start_q;
    assign tb_busy_out   = busy;
    assign tb_done_out   = tb_done_q;
    assign overrun_out   = overrun_q;
    assign wbank_out     = wbank_q;

endmodule

// File: tb/tb_spm_bank_scheduler.sv
// Self-checking bench for spm_bank_scheduler (default build).
// Six behavioural synchronous-read banks sit on the bank ports. A reference
// model of the scheduling rules tracks write/read pointers and the expected
// bank contents; expected read words go into a scoreboard queue when a
// request is driven and are popped when rd_valid_out appears.
module tb_spm_bank_scheduler;

    localparam int WIDTH = 64;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             sym_valid_in = 1'b0;
    logic [WIDTH-1:0] wdata_in = '0;
    logic             tb_rd_req_in = 1'b0;
    logic [WIDTH-1:0] brd [6];
    logic [AW-1:0]    addr0_out, addr1_out, addr2_out, addr3_out, addr4_out, addr5_out;
    logic [5:0]       cs_out, we_out;
    logic [WIDTH-1:0] wdata_out, rdata_out;
    logic             rd_valid_out, rd_decode_out, tb_start_out, tb_busy_out;
    logic             tb_done_out, overrun_out;
    logic [2:0]       wbank_out;

    always #5 clk = ~clk;

    spm_bank_scheduler #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .sym_valid_in(sym_valid_in), .wdata_in(wdata_in), .tb_rd_req_in(tb_rd_req_in),
        .rdata0_in(brd[0]), .rdata1_in(brd[1]), .rdata2_in(brd[2]),
        .rdata3_in(brd[3]), .rdata4_in(brd[4]), .rdata5_in(brd[5]),
        .addr0_out(addr0_out), .addr1_out(addr1_out), .addr2_out(addr2_out),
        .addr3_out(addr3_out), .addr4_out(addr4_out), .addr5_out(addr5_out),
        .cs_out(cs_out), .we_out(we_out), .wdata_out(wdata_out),
        .rdata_out(rdata_out), .rd_valid_out(rd_valid_out), .rd_decode_out(rd_decode_out),
        .tb_start_out(tb_start_out), .tb_busy_out(tb_busy_out), .tb_done_out(tb_done_out),
        .overrun_out(overrun_out), .wbank_out(wbank_out)
    );

    // ------------------------------------------------ behavioural banks
    logic [WIDTH-1:0] mem [6][32];
    logic [AW-1:0]    baddr [6];
    assign baddr[0] = addr0_out;
    assign baddr[1] = addr1_out;
    assign baddr[2] = addr2_out;
    assign baddr[3] = addr3_out;
    assign baddr[4] = addr4_out;
    assign baddr[5] = addr5_out;

    initial begin
        for (int b = 0; b < 6; b++) begin
            brd[b] = '0;
            for (int a = 0; a < 32; a++) mem[b][a] = '0;
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < 6; b++) begin
            if (cs_out[b]) begin
                if (we_out[b]) mem[b][baddr[b]] <= wdata_out;
                else           brd[b] <= mem[b][baddr[b]];
            end
        end
    end

    // ------------------------------------------------ checking helpers
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        bit          dec;
        bit          last;
    } rd_exp_t;

    rd_exp_t sb[$];

    // Reference model state
    int          m_wbank, m_wptr, m_fill, m_rbank, m_raddr, m_rcnt;
    bit          m_busy, m_ovr, pend_vld;
    logic [63:0] exp_mem [6][32];
    int          n_done, n_start, g_sym;

    function automatic logic [63:0] pat(input int n);
        return {32'(n) ^ 32'hA5C3_0000, ~32'(n)};
    endfunction

    task automatic model_reset();
        m_wbank = 0; m_wptr = 0; m_fill = 0; m_rbank = 0; m_raddr = 0; m_rcnt = 0;
        m_busy = 0; m_ovr = 0; pend_vld = 0;
        n_done = 0; n_start = 0;
        sb.delete();
    endtask

    // One clock: drive inputs, advance the model, then compare #1 after the edge.
    task automatic cycle(input bit sv, input logic [63:0] wd, input bit rq);
        int wb, wa, rb, ra;
        bit bnd, st, rd_do;
        logic [5:0] ecs, ewe;
        rd_exp_t e;
        wb = m_wbank; wa = m_wptr; rb = m_rbank; ra = m_raddr;
        bnd   = sv && (m_wptr == 31);
        st    = bnd && (m_fill >= 4);
        rd_do = rq && m_busy && !bnd;
        if (rd_do) begin
            e.data = exp_mem[rb][ra];
            e.dec  = (m_rcnt >= 128);
            e.last = (m_rcnt == 159);
            sb.push_back(e);
            m_rcnt++;
            if (ra == 0) begin m_raddr = 31; m_rbank = (rb + 5) % 6; end
            else m_raddr = ra - 1;
            if (e.last) m_busy = 0;
        end
        if (sv) begin
            exp_mem[wb][wa] = wd;
            m_wptr = (wa + 1) % 32;
            if (bnd) begin
                m_wbank = (wb + 1) % 6;
                if (m_fill < 5) m_fill++;
            end
        end
        if (st) begin
            if (m_busy) m_ovr = 1;
            m_busy = 1; m_rbank = wb; m_raddr = 31; m_rcnt = 0;
        end

        sym_valid_in = sv; wdata_in = wd; tb_rd_req_in = rq;
        @(posedge clk);
        #1;
        sym_valid_in = 1'b0; wdata_in = '0; tb_rd_req_in = 1'b0;

        ecs = '0; ewe = '0;
        if (sv) begin ecs[wb] = 1'b1; ewe[wb] = 1'b1; end
        if (rd_do) ecs[rb] = 1'b1;
        check("cs_out", cs_out, ecs);
        check("we_out", we_out, ewe);
        if (sv) begin
            check("write_addr", baddr[wb], wa);
            check("wdata_out", wdata_out, wd);
        end
        if (rd_do) check("read_addr", baddr[rb], ra);
        check("tb_start_out", tb_start_out, st);
        check("wbank_out", wbank_out, m_wbank);
        check("tb_busy_out", tb_busy_out, m_busy);
        check("overrun_out", overrun_out, m_ovr);
        check("rd_valid_out", rd_valid_out, pend_vld);
        if (tb_start_out) n_start++;
        if (rd_valid_out) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard: rd_valid_out with no outstanding read");
            end else begin
                e = sb.pop_front();
                check("rdata_out", rdata_out, e.data);
                check("rd_decode_out", rd_decode_out, e.dec);
                check("tb_done_out", tb_done_out, e.last);
                if (tb_done_out) n_done++;
            end
        end else begin
            check("tb_done_idle", tb_done_out, 0);
        end
        pend_vld = rd_do;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cs"}, cs_out, 0);
        check({tag, "_we"}, we_out, 0);
        check({tag, "_addr"}, {addr0_out, addr1_out, addr2_out, addr3_out, addr4_out, addr5_out}, 0);
        check({tag, "_wdata"}, wdata_out, 0);
        check({tag, "_rdata"}, rdata_out, 0);
        check({tag, "_rd_valid"}, rd_valid_out, 0);
        check({tag, "_rd_decode"}, rd_decode_out, 0);
        check({tag, "_start"}, tb_start_out, 0);
        check({tag, "_busy"}, tb_busy_out, 0);
        check({tag, "_done"}, tb_done_out, 0);
        check({tag, "_overrun"}, overrun_out, 0);
        check({tag, "_wbank"}, wbank_out, 0);
    endtask

    // First-window vectors: {inputs, expected outputs}
    typedef struct {
        bit          sv;
        logic [63:0] wd;
        logic [5:0]  exp_we;
        logic [4:0]  exp_addr0;
        logic [2:0]  exp_wbank;
        bit          exp_start;
    } vec_t;

    vec_t vt [33];
    int   wrap_bank [5];

    initial begin
        for (int k = 0; k < 32; k++)
            vt[k] = '{1'b1, 64'(k), 6'b000001, 5'(k), (k == 31) ? 3'd1 : 3'd0, 1'b0};
        vt[32] = '{1'b0, 64'd0, 6'b000000, 5'd0, 3'd1, 1'b0};
        wrap_bank = '{0, 5, 4, 3, 2};
        for (int b = 0; b < 6; b++)
            for (int a = 0; a < 32; a++) exp_mem[b][a] = '0;
        model_reset();
        g_sym = 1000;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // First window from the vector table
        for (int i = 0; i < 33; i++) begin
            cycle(vt[i].sv, vt[i].wd, 1'b0);
            check("tbl_we", we_out, vt[i].exp_we);
            check("tbl_addr0", addr0_out, vt[i].exp_addr0);
            check("tbl_wbank", wbank_out, vt[i].exp_wbank);
            check("tbl_start", tb_start_out, vt[i].exp_start);
        end

        // Windows 2..5: a single start pulse after the 160th write, c = 4
        for (int i = 0; i < 128; i++) begin
            cycle(1'b1, pat(g_sym), 1'b0);
            g_sym++;
        end
        check("start_after_160", tb_start_out, 1);
        check("wbank_after_160", wbank_out, 5);
        check("start_count_160", n_start, 1);

        // Read 10 words from c = 4, then close window 6 -> overrun
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (i == 0) begin
                check("first_read_cs", cs_out, 6'b010000);
                check("first_read_addr4", addr4_out, 31);
            end
        end
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, pat(g_sym), 1'b0);
            g_sym++;
        end
        check("overrun_set", overrun_out, 1);
        check("restart_pulse", tb_start_out, 1);
        cycle(1'b0, '0, 1'b1);
        check("restart_cs", cs_out, 6'b100000);
        check("restart_addr5", addr5_out, 31);
        check("no_done_after_abort", n_done, 0);

        // Finish the c = 5 sequence: continuous reads, a write every 8 cycles
        for (int i = 1; i < 160; i++) begin
            cycle(i % 8 == 3, pat(g_sym), 1'b1);
            if (i % 8 == 3) g_sym++;
            if (i == 128) begin
                check("c5_decode_cs", cs_out, 6'b000010);
                check("c5_decode_addr1", addr1_out, 31);
            end
        end
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("done_count_c5", n_done, 1);
        check("scoreboard_drained", sb.size(), 0);

        // Complete bank 0 -> c = 0 wrap case (traceback 0,5,4,3; decode 2; write 1)
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, pat(g_sym), 1'b0);
            g_sym++;
        end
        check("wrap_start", tb_start_out, 1);
        check("wrap_wbank", wbank_out, 1);
        for (int i = 0; i < 160; i++) begin
            cycle(i % 8 == 5, pat(g_sym), 1'b1);
            if (i % 8 == 5) g_sym++;
            if (i % 32 == 0) check("wrap_bank_order", cs_out, 6'b1 << wrap_bank[i / 32]);
        end
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("done_count_wrap", n_done, 2);
        check("overrun_sticky", overrun_out, 1);

        // Reset in the middle of a sequence
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, pat(g_sym), 1'b0);
            g_sym++;
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        for (int b = 0; b < 6; b++)
            for (int a = 0; a < 32; a++) exp_mem[b][a] = mem[b][a];
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 128; i++) begin
            cycle(1'b1, pat(g_sym), 1'b0);
            g_sym++;
        end
        check("no_start_after_4", n_start, 0);
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, pat(g_sym), 1'b0);
            g_sym++;
        end
        check("start_after_5_post_reset", n_start, 1);
        check("post_reset_overrun_clear", overrun_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spm_bank_scheduler.md
# spm_bank_scheduler

Survivor-path memory scheduler for the Viterbi decoder. It owns the six 32x64 survivor banks and rotates their roles every 32 trellis steps: one write bank, four traceback banks and one decode bank. It turns per-step survivor words from the path-metric side into bank writes, and turns read requests from the traceback engine into bank reads in descending trellis order. Write and read traffic is scheduled onto disjoint banks in the same cycle, and traceback overrun is detected.

## Interface
Parameters:
- WIDTH, 64, survivor word width (one decision bit per state)
- AW, 5, bank address width (bank depth 2**AW = 32)

Ports:
- clk  in  1  decoder clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sym_valid_in  in  1  one-cycle pulse: new survivor word for one trellis step
- wdata_in  in  WIDTH  survivor word, valid with sym_valid_in
- tb_rd_req_in  in  1  traceback engine requests next read (one per cycle max)
- rdata0_in..rdata5_in  in  WIDTH  synchronous-read data from banks 0..5
- addr0_out..addr5_out  out  AW  per-bank address
- cs_out  out  6  per-bank chip select, active high
- we_out  out  6  per-bank write strobe, active high
- wdata_out  out  WIDTH  write data, shared by all banks
- rdata_out  out  WIDTH  read word returned to traceback engine
- rd_valid_out  out  1  rdata_out valid
- rd_decode_out  out  1  current read word comes from the decode bank
- tb_start_out  out  1  pulse: a new traceback window is ready
- tb_busy_out  out  1  traceback sequence in progress
- tb_done_out  out  1  pulse with the last read word of a sequence
- overrun_out  out  1  sticky: window boundary reached while busy
- wbank_out  out  3  current write-bank index 0..5

## Operation
- State:
  - wbank: 0..5
  - wptr: 0..31
  - fill: completed windows, saturates at 5
  - rd_bank, rd_addr, rd_cnt: 0..159
  - busy
- Write path:
  - sym_valid_in writes wdata_in to bank wbank at address wptr, then wptr++.
  - On the write at wptr=31 (boundary), completed bank c=wbank; wbank becomes (wbank+1) mod 6, wptr becomes 0, and fill++.
- Boundary with fill reaching or already at 5:
  - tb_start_out pulses and busy sets.
  - rd_bank=c, rd_addr=31, rd_cnt=0.
- Read sequence:
  - Each tb_rd_req_in while busy issues a read at (rd_bank, rd_addr), then rd_addr--.
  - rd_addr wraps 0→31 with rd_bank=(rd_bank−1) mod 6.
  - Reads 0..127 cover traceback banks c, c−1, c−2, c−3. Reads 128..159 cover decode bank c−4, with rd_decode_out=1.
  - Read 159 clears busy and pulses tb_done_out with its data.
- Ignored or overlapping events:
  - tb_rd_req_in while not busy is ignored.
  - sym_valid_in and tb_rd_req_in in the same cycle are both serviced. The write bank is never in the read set, so there is no conflict.
- Overrun (boundary while busy): overrun_out sets, the running sequence is aborted (no tb_done_out), and the new sequence restarts at the new c. A read request in the boundary cycle is dropped.
- Bank index arithmetic is always mod 6, via the package helper.

## Timing
- Write: sym_valid_in at cycle t → we_out, cs_out, addr and wdata_out registered at t+1, asserted for one cycle.
- Read: tb_rd_req_in at t → cs_out and addr at t+1 (we=0) → rd_valid_out and rdata_out at t+2.
  - rdata_out is a combinational 6:1 mux using the bank index delayed by 2 cycles.
  - Reads are fully pipelined, one per cycle.
- Control pulses: tb_start_out and wbank_out update at t+1 after the boundary write request.
- Reset values: all outputs 0, wbank=0, wptr=0, fill=0, busy=0. overrun_out clears only on reset.
- Reset asserted mid-sequence clears all pipeline stages. No rd_valid_out follows reset.

## Configuration
- SPM_SCHED_OVR_CNT_EN defined: adds output port ovr_cnt_out[7:0]. It increments on each overrun event, saturates at 255, and resets to 0.
- Undefined: port and counter absent; only the sticky overrun_out is present.

## Structure
- Package spm_sched_pkg:
  - constants NBANK=6, TB_BANKS=4, TB_READS=160
  - typedef bank_idx_t (3 bits)
  - functions bank_dec/bank_inc (mod 6)
- Sub-module spm_bank_rdmux: registered bank select plus the 6:1 WIDTH-bit read mux.

## Test plan
- Reset, then 32 sym_valid_in with wdata=k (k=0..31):
  - we_out=6'b000001, addr0_out=0..31, wdata_out=k at t+1.
  - Afterwards wbank_out=1; no tb_start_out.
- 160 symbols (5 windows): tb_start_out pulses once, after the 160th write; c=4.
  - The first read asserts cs_out=6'b010000 with addr4_out=31.
  - The 129th read asserts cs_out=6'b000001 with addr0_out=31 and rd_decode_out=1.
  - tb_done_out pulses with the 160th rd_valid_out.
- Continuous tb_rd_req_in with sym_valid_in every 8 cycles:
  - Same-cycle writes and reads hit different banks.
  - Data returns 2 cycles after each request, matching the words written earlier.
- Read 10 words, then deliver 32 more symbols:
  - overrun_out=1, no tb_done_out.
  - The next read goes to bank 5 at address 31.
- Wrap case, c=0: decode bank is 2 and traceback order is 0,5,4,3; bank 1 is the write bank.
- Assert reset_n low mid-sequence: all outputs 0 immediately and busy=0. After reset, 5 new windows are required before tb_start_out.
